sa_input_skew: RTL and testbench
================================

SA_INPUT_SKEW -- requirements
Module: sa_input_skew

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, activation width in bits.
REQ-002 SHALL have parameter N_SIZE, default 16, lane count (array rows); legal range 2..32.
REQ-003 SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  array advance enable; 0 freezes all state.
REQ-006 SHALL have port in_valid  input  1  in_data holds a vector.
REQ-007 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-008 SHALL have port in_last  input  1  the current beat is the final vector of the tile.
REQ-009 SHALL have port in_data  input  DATAWIDTH x N_SIZE (unpacked [N_SIZE])  one activation per lane.
REQ-010 SHALL have port act_out  output  DATAWIDTH x N_SIZE (unpacked [N_SIZE])  skewed activations to the array rows.
REQ-011 SHALL have port act_valid  output  N_SIZE  per-lane valid qualifying act_out.
REQ-012 SHALL have port busy  output  1  high when the FSM is not in IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the final vector has left lane N_SIZE-1.

Function
REQ-014 SHALL delay lane k by exactly k advance cycles, where an advance cycle is any cycle with en=1; lane 0 is a combinational pass-through of the accepted beat.
REQ-015 SHALL accept a beat only when in_valid and in_ready are both high; in_ready = en AND (state is IDLE or STREAM).
REQ-016 SHALL inject a bubble (data 0, valid 0) into every lane on an advance cycle with no accepted beat.
REQ-017 SHALL drive act_out[k]=0 whenever act_valid[k]=0.
REQ-018 SHALL hold all stage registers, the FSM and the counter unchanged when en=0; act_out and act_valid stay stable during the stall.
REQ-019 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-020 SHALL transition IDLE->STREAM on an accepted beat with in_last=0.
REQ-021 SHALL transition IDLE->DRAIN or STREAM->DRAIN on an accepted beat with in_last=1.
REQ-022 SHALL stay in STREAM across bubbles (in_valid=0) without timeout.
REQ-023 SHALL load a drain counter with N_SIZE-1 on entry to DRAIN and decrement it on each advance cycle; on the advance cycle where it reaches 0 it SHALL pulse done and return to IDLE.
REQ-024 SHALL size the drain counter as $clog2(N_SIZE) bits.
REQ-025 SHALL not accept a new tile during DRAIN (in_ready=0); the first beat of the next tile is accepted in IDLE, at the earliest one cycle after done.
REQ-026 SHALL pass data bit-exact, with no arithmetic or width change.

Reset
REQ-027 SHALL, while rst_n=0, clear all stage data and valid registers to 0, set the FSM to IDLE and set the counter to 0; asynchronous assertion.
REQ-028 SHALL drive, in reset, in_ready=0, act_valid=0, act_out=0, busy=0 and done=0.
REQ-029 SHALL discard any in-flight tile when reset is asserted mid-operation; no done pulse follows the discarded tile.

Structure
REQ-030 SHALL take DATAWIDTH, N_SIZE defaults and the FSM state enum from the shared package sa_pkg.
REQ-031 SHALL instantiate sub-module sa_skew_lane (parameter DEPTH, with data and valid shift registers and an enable input) once per lane k>=1, with DEPTH=k; total stages = N_SIZE*(N_SIZE-1)/2.

Verification (bench uses N_SIZE=4, DATAWIDTH=8)
REQ-032 SHALL cover single beat: en=1, in_data={1,2,3,4} with in_last=1 -> act_valid[0] set same cycle with act_out[0]=1; lane k valid with value k+1 exactly k cycles later; done pulses 3 cycles after accept.
REQ-033 SHALL cover a streaming tile: 5 back-to-back beats {10n,10n+1,10n+2,10n+3}, n=0..4, last on n=4 -> each lane emits 5 consecutive valid values in order, lane k offset by k; done 3 cycles after beat 4.
REQ-034 SHALL cover a stall: en=0 for 2 cycles mid-tile -> outputs frozen, no value lost or duplicated, done delayed by exactly 2 cycles.
REQ-035 SHALL cover bubbles: in_valid=0 between beats -> matching act_valid=0 / act_out=0 holes appear skewed per lane; FSM stays STREAM.
REQ-036 SHALL cover backpressure in DRAIN: in_valid=1 held during DRAIN -> in_ready=0 and no accept; the beat is accepted the cycle after done.
REQ-037 SHALL cover reset mid-DRAIN: rst_n low for 1 cycle -> all act_valid=0, busy=0 and no done pulse.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants and FSM state encoding for the systolic-array input skew block.
package sa_pkg;

  // Default activation width and lane count for the array front end.
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_N_SIZE    = 16;

  // Tile sequencing: waiting for a tile, accepting beats, flushing the skew.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/sa_input_skew_if.sv
// Input vector handshake plus the skewed per-row activation bus.
interface sa_input_skew_if
  import sa_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_SIZE    = DEF_N_SIZE
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [DATAWIDTH-1:0] in_data [N_SIZE];
  logic [DATAWIDTH-1:0] act_out [N_SIZE];
  logic [N_SIZE-1:0]    act_valid;

  // Producer of vectors / consumer of skewed activations.
  modport master (
    output in_valid, in_last, in_data,
    input  in_ready, act_out, act_valid
  );

  // The skew block itself.
  modport slave (
    input  in_valid, in_last, in_data,
    output in_ready, act_out, act_valid
  );

endinterface

// File: rtl/sa_skew_lane.sv
// One lane of the skew buffer: a DEPTH-stage data/valid shift register that
// only moves on cycles where en is high.
module sa_skew_lane #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid
);

  logic [DATAWIDTH-1:0] data_sr  [DEPTH];
  logic [DEPTH-1:0]     valid_sr;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // First stage captures the (already bubble-gated) lane input.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_sr[0]  <= '0;
            valid_sr[0] <= 1'b0;
          end else if (en) begin
            data_sr[0]  <= in_data;
            valid_sr[0] <= in_valid;
          end
        end
      end else begin : g_body
        // Later stages copy their predecessor on every advance cycle.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_sr[gi]  <= '0;
            valid_sr[gi] <= 1'b0;
          end else if (en) begin
            data_sr[gi]  <= data_sr[gi-1];
            valid_sr[gi] <= valid_sr[gi-1];
          end
        end
      end
    end
  endgenerate

  // Bubbles enter with zero data, so the tail needs no extra masking.
  assign out_data  = data_sr[DEPTH-1];
  assign out_valid = valid_sr[DEPTH-1];

endmodule

// File: rtl/sa_input_skew.sv
// Input skew buffer for an N_SIZE-row systolic array: lane k is delayed by k
// advance cycles, and a small FSM tracks tile boundaries and signals when the
// final vector of a tile has left the deepest lane.
module sa_input_skew
  import sa_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_SIZE    = DEF_N_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  sa_input_skew_if.slave  bus,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = $clog2(N_SIZE);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               in_ready;
  logic               accept;
  logic [DATAWIDTH-1:0] lane_in  [N_SIZE];
  logic [DATAWIDTH-1:0] lane_out [N_SIZE];
  logic [N_SIZE-1:0]    lane_vld;

  // Gating with rst_n keeps the handshake quiet while reset is held.
  assign in_ready = rst_n && en && ((state_reg == IDLE) || (state_reg == STREAM));
  assign accept   = bus.in_valid && in_ready;
  assign busy     = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < N_SIZE; gi++) begin : g_lane
      // A cycle without an accepted beat injects a zero-data bubble.
      assign lane_in[gi] = accept ? bus.in_data[gi] : '0;
      if (gi == 0) begin : g_pass
        assign lane_out[0] = lane_in[0];
        assign lane_vld[0] = accept;
      end else begin : g_skew
        sa_skew_lane #(
          .DATAWIDTH (DATAWIDTH),
          .DEPTH     (gi)
        ) u_lane (
          .clk       (clk),
          .rst_n     (rst_n),
          .en        (en),
          .in_data   (lane_in[gi]),
          .in_valid  (accept),
          .out_data  (lane_out[gi]),
          .out_valid (lane_vld[gi])
        );
      end
    end
  endgenerate

  assign bus.in_ready  = in_ready;
  assign bus.act_out   = lane_out;
  assign bus.act_valid = lane_vld;

  // State and drain counter registers; frozen whenever en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state: a last beat starts an (N_SIZE-1)-cycle drain; done fires on
  // the advance that takes the counter from 1 to 0, i.e. when the final
  // vector is on the deepest lane's output.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done       = 1'b0;
    if (en) begin
      case (state_reg)
        IDLE, STREAM: begin
          if (accept) begin
            if (bus.in_last) begin
              state_next = DRAIN;
              cnt_next   = CNT_W'(N_SIZE - 1);
            end else begin
              state_next = STREAM;
            end
          end
        end
        DRAIN: begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_input_skew.sv
// Self-checking bench for sa_input_skew (N_SIZE=4, DATAWIDTH=8) with a
// history-based reference: lane k shows whatever was injected k advances ago.
module tb_sa_input_skew;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic busy, done;

  sa_input_skew_if #(.DATAWIDTH(DW), .N_SIZE(N)) bus ();

  sa_input_skew #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference state: one entry per advance cycle.
  bit          hv [HMAX];
  logic [31:0] hd [HMAX];
  int adv      = 0;
  int base     = 0;
  int last_idx = -1;
  bit open_t   = 1'b0;
  int errors   = 0;
  int checks   = 0;

  function automatic logic [31:0] pk(int a, int b, int c, int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {d8, c8, b8, a8};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h adv=%0d", tag, obs, exp, adv);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at posedge.
  task automatic cycle(bit e, bit v, bit l, logic [31:0] dv);
    bit draining, exp_ready, acc, exp_done, exp_busy, ev;
    logic [7:0] ed;
    int idx;
    en = e;
    bus.in_valid = v;
    bus.in_last  = l;
    for (int k = 0; k < N; k++) bus.in_data[k] = dv[k*8 +: 8];
    @(negedge clk);
    draining  = (last_idx >= 0) && (adv > last_idx) && (adv <= last_idx + N - 1);
    exp_ready = rst_n && e && !draining;
    acc       = v && exp_ready;
    exp_done  = rst_n && e && (last_idx >= 0) && (adv == last_idx + N - 1);
    exp_busy  = rst_n && (open_t || draining);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        ev = acc;
        ed = acc ? dv[7:0] : 8'd0;
      end else begin
        idx = adv - k;
        ev  = (idx >= base) ? hv[idx] : 1'b0;
        ed  = (idx >= base) ? hd[idx][k*8 +: 8] : 8'd0;
      end
      if (!rst_n) begin
        ev = 1'b0;
        ed = 8'd0;
      end
      chk($sformatf("act_valid[%0d]", k), {31'd0, bus.act_valid[k]}, {31'd0, ev});
      chk($sformatf("act_out[%0d]", k), {24'd0, bus.act_out[k]}, {24'd0, ed});
    end
    @(posedge clk);
    if (!rst_n) begin
      base     = adv;
      last_idx = -1;
      open_t   = 1'b0;
    end else if (e) begin
      hv[adv] = acc;
      hd[adv] = acc ? dv : 32'd0;
      if (acc) begin
        if (l) begin
          last_idx = adv;
          open_t   = 1'b0;
        end else begin
          open_t = 1'b1;
        end
      end
      adv++;
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int k = 0; k < N; k++) bus.in_data[k] = '0;

    // Reset state, even with a valid beat offered.
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, pk(9, 9, 9, 9));
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single-beat tile.
    cycle(1'b1, 1'b1, 1'b1, pk(1, 2, 3, 4));
    idle(5);

    // Five back-to-back beats.
    for (int n = 0; n < 5; n++) cycle(1'b1, 1'b1, n == 4, pk(10*n, 10*n+1, 10*n+2, 10*n+3));
    idle(5);

    // Two-cycle stall in the middle of a tile.
    for (int n = 0; n < 6; n++) begin
      if (n == 3) begin
        cycle(1'b0, 1'b1, 1'b0, pk(70, 71, 72, 73));
        cycle(1'b0, 1'b1, 1'b0, pk(70, 71, 72, 73));
      end
      cycle(1'b1, 1'b1, n == 5, pk(50+n, 60+n, 70+n, 80+n));
    end
    idle(6);

    // Bubbles between beats.
    cycle(1'b1, 1'b1, 1'b0, pk(101, 102, 103, 104));
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, pk(111, 112, 113, 114));
    idle(2);
    cycle(1'b1, 1'b1, 1'b1, pk(121, 122, 123, 124));
    idle(5);

    // Valid held high through DRAIN: next beat waits for the cycle after done.
    cycle(1'b1, 1'b1, 1'b1, pk(200, 201, 202, 203));
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, pk(170, 171, 172, 173));
    idle(5);

    // Reset in the middle of a drain.
    cycle(1'b1, 1'b1, 1'b1, pk(31, 32, 33, 34));
    idle(1);
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Randomized traffic with occasional stalls.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0, $urandom);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
